// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution and an
// iterative shift-add MUL / restoring DIV unit that stalls the front of the pipe.
module exe_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] val1_in,
    input  logic [WIDTH-1:0] val2_in,
    input  logic [WIDTH-1:0] reg2_in,
    input  logic [3:0]       ex_cmd,
    input  logic [1:0]       branch_type,
    input  logic             wb_en_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [4:0]       dst_in,
    input  logic [1:0]       fwd_sel_a,
    input  logic [1:0]       fwd_sel_b,
    input  logic [1:0]       fwd_sel_st,
    input  logic [WIDTH-1:0] mem_fwd,
    input  logic [WIDTH-1:0] wb_fwd,
    input  logic             kill,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] st_data,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_addr,
    output logic             wb_en_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic [4:0]       dst_out,
    output logic             stall,
    output logic             mc_busy
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [3:0] CmdAdd = 4'd0;
    localparam logic [3:0] CmdSub = 4'd1;
    localparam logic [3:0] CmdAnd = 4'd2;
    localparam logic [3:0] CmdOr  = 4'd3;
    localparam logic [3:0] CmdNor = 4'd4;
    localparam logic [3:0] CmdXor = 4'd5;
    localparam logic [3:0] CmdSll = 4'd6;
    localparam logic [3:0] CmdSra = 4'd7;
    localparam logic [3:0] CmdSrl = 4'd8;
    localparam logic [3:0] CmdMul = 4'd9;
    localparam logic [3:0] CmdDiv = 4'd10;

    localparam logic [1:0] BrBez = 2'b01;
    localparam logic [1:0] BrBne = 2'b10;
    localparam logic [1:0] BrJmp = 2'b11;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] id_val,
                                                 input logic [WIDTH-1:0] mem_val,
                                                 input logic [WIDTH-1:0] wb_val);
        case (sel)
            2'b01:   return mem_val;
            2'b10:   return wb_val;
            default: return id_val;
        endcase
    endfunction

    logic [WIDTH-1:0] op_a, op_b, op_s;
    logic [CntW-1:0]  shamt;
    logic [WIDTH-1:0] alu_comb;
    logic             br_cond;

    assign op_a    = fwd_mux(fwd_sel_a, val1_in, mem_fwd, wb_fwd);
    assign op_b    = fwd_mux(fwd_sel_b, val2_in, mem_fwd, wb_fwd);
    assign op_s    = fwd_mux(fwd_sel_st, reg2_in, mem_fwd, wb_fwd);
    assign st_data = op_s;
    assign shamt   = op_b[CntW-1:0];

    always_comb begin
        alu_comb = '0;
        case (ex_cmd)
            CmdAdd:  alu_comb = op_a + op_b;
            CmdSub:  alu_comb = op_a - op_b;
            CmdAnd:  alu_comb = op_a & op_b;
            CmdOr:   alu_comb = op_a | op_b;
            CmdNor:  alu_comb = ~(op_a | op_b);
            CmdXor:  alu_comb = op_a ^ op_b;
            CmdSll:  alu_comb = op_a << shamt;
            CmdSra:  alu_comb = $signed(op_a) >>> shamt;
            CmdSrl:  alu_comb = op_a >> shamt;
            CmdMul:  alu_comb = '0;
            CmdDiv:  alu_comb = '0;
            default: alu_comb = op_b;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        br_addr = pc_in + (op_b << 2);
        case (branch_type)
            BrBez:   br_cond = (op_a == '0);
            BrBne:   br_cond = (op_a != op_s);
            BrJmp: begin
                br_cond = 1'b1;
                br_addr = op_b;
            end
            default: br_cond = 1'b0;
        endcase
    end

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] mc_a_q, mc_a_d;
    logic [WIDTH-1:0] mc_b_q, mc_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] mc_result_q, mc_result_d;
    logic             is_div_q, is_div_d;
    logic             start;
    logic [WIDTH:0]   trial;
    logic             trial_ge;

    // Flushed ID/EX entries carry wb_en=0 and must never launch an operation.
    assign start = !rst && (state_q == StIdle) && wb_en_in &&
                   ((ex_cmd == CmdMul) || (ex_cmd == CmdDiv));

    // Restoring division: dividend bits shift out of mc_a while quotient bits shift in.
    assign trial    = {rem_q, mc_a_q[WIDTH-1]};
    assign trial_ge = (trial >= {1'b0, mc_b_q});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mc_a_d      = mc_a_q;
        mc_b_d      = mc_b_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        mc_result_d = mc_result_q;
        is_div_d    = is_div_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mc_a_d   = op_a;
                    mc_b_d   = op_b;
                    acc_d    = '0;
                    rem_d    = '0;
                    cnt_d    = '0;
                    is_div_d = (ex_cmd == CmdDiv);
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (is_div_q) begin
                    mc_a_d = {mc_a_q[WIDTH-2:0], trial_ge};
                    rem_d  = trial_ge ? (trial[WIDTH-1:0] - mc_b_q) : trial[WIDTH-1:0];
                end else begin
                    acc_d  = acc_q + (mc_b_q[0] ? mc_a_q : '0);
                    mc_a_d = mc_a_q << 1;
                    mc_b_d = mc_b_q >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (kill) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    mc_result_d = is_div_q ? mc_a_d : acc_d;
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mc_a_q      <= '0;
            mc_b_q      <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            mc_result_q <= '0;
            is_div_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mc_a_q      <= mc_a_d;
            mc_b_q      <= mc_b_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            mc_result_q <= mc_result_d;
            is_div_q    <= is_div_d;
        end
    end

    assign stall   = start || (!rst && (state_q == StBusy));
    assign mc_busy = (state_q != StIdle);

    assign alu_result    = (state_q == StDone) ? mc_result_q : alu_comb;
    assign br_taken      = br_cond && !stall;
    assign wb_en_out     = wb_en_in && !stall;
    assign mem_read_out  = mem_read_in && !stall;
    assign mem_write_out = mem_write_in && !stall;
    assign dst_out       = dst_in;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboarded bench for exe_stage: forwarding, ALU ops, branches, MUL/DIV timing,
// flush, kill and asynchronous reset.
module tb_exe_stage;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc_in, val1_in, val2_in, reg2_in, mem_fwd, wb_fwd;
    logic [3:0]   ex_cmd;
    logic [1:0]   branch_type, fwd_sel_a, fwd_sel_b, fwd_sel_st;
    logic         wb_en_in, mem_read_in, mem_write_in, kill;
    logic [4:0]   dst_in, dst_out;
    logic [W-1:0] alu_result, st_data, br_addr;
    logic         br_taken, wb_en_out, mem_read_out, mem_write_out, stall, mc_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    exe_stage #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .val1_in      (val1_in),
        .val2_in      (val2_in),
        .reg2_in      (reg2_in),
        .ex_cmd       (ex_cmd),
        .branch_type  (branch_type),
        .wb_en_in     (wb_en_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .dst_in       (dst_in),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .fwd_sel_st   (fwd_sel_st),
        .mem_fwd      (mem_fwd),
        .wb_fwd       (wb_fwd),
        .kill         (kill),
        .alu_result   (alu_result),
        .st_data      (st_data),
        .br_taken     (br_taken),
        .br_addr      (br_addr),
        .wb_en_out    (wb_en_out),
        .mem_read_out (mem_read_out),
        .mem_write_out(mem_write_out),
        .dst_out      (dst_out),
        .stall        (stall),
        .mc_busy      (mc_busy)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic score(input string tag);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, " (scoreboard empty)"}, alu_result, ~alu_result);
        end else begin
            exp = exp_q.pop_front();
            check(tag, alu_result, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [W-1:0] v1, input logic [W-1:0] v2,
                         input logic [W-1:0] r2, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] sst, input logic [1:0] bt, input logic wb);
        ex_cmd      = cmd;
        val1_in     = v1;
        val2_in     = v2;
        reg2_in     = r2;
        fwd_sel_a   = sa;
        fwd_sel_b   = sb;
        fwd_sel_st  = sst;
        branch_type = bt;
        wb_en_in    = wb;
    endtask

    task automatic alu_test(input string tag, input logic [3:0] cmd, input logic [W-1:0] v1,
                            input logic [W-1:0] v2, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [W-1:0] exp);
        @(negedge clk);
        drive(cmd, v1, v2, 32'h0, sa, sb, 2'b00, 2'b00, 1'b1);
        exp_q.push_back(exp);
        #2;
        score(tag);
    endtask

    task automatic br_test(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] s, input logic [1:0] bt, input logic exp_taken,
                           input logic [W-1:0] exp_addr);
        @(negedge clk);
        pc_in = 32'h100;
        drive(4'd0, a, b, s, 2'b00, 2'b00, 2'b00, bt, 1'b0);
        #2;
        check({tag, " taken"}, 32'(br_taken), 32'(exp_taken));
        check({tag, " addr"}, br_addr, exp_addr);
    endtask

    task automatic run_mc(input string tag, input logic [3:0] cmd, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int   n_stall;
        logic bubble_ok;
        @(posedge clk);
        #1;
        drive(cmd, a, b, 32'h0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
        mem_write_in = 1'b1;
        exp_q.push_back(exp);
        n_stall   = 0;
        bubble_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            if (wb_en_out || mem_write_out || br_taken) bubble_ok = 1'b0;
        end
        check({tag, " stall cycles"}, 32'(n_stall), 32'd33);
        check({tag, " bubbles during stall"}, 32'(bubble_ok), 32'd1);
        check({tag, " busy in done"}, 32'(mc_busy), 32'd1);
        score({tag, " result"});
        check({tag, " wb_en_out in done"}, 32'(wb_en_out), 32'd1);
        @(posedge clk);
        #1;
        check({tag, " busy after done"}, 32'(mc_busy), 32'd0);
        drive(4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        mem_write_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        pc_in        = 32'h0;
        mem_fwd      = 32'd7;
        wb_fwd       = 32'd1;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        dst_in       = 5'd9;
        kill         = 1'b0;
        drive(4'd9, 32'd2, 32'd3, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset mc_busy", 32'(mc_busy), 32'd0);
        ex_cmd = 4'd0;
        exp_q.push_back(32'd5);
        #1;
        score("reset comb add");
        check("dst passthrough", 32'(dst_out), 32'd9);
        @(negedge clk);
        rst = 1'b0;

        alu_test("fwd a mem", 4'd0, 32'd5, 32'd3, 2'b01, 2'b00, 32'd10);
        alu_test("fwd a wb", 4'd0, 32'd5, 32'd3, 2'b10, 2'b00, 32'd4);
        alu_test("fwd a sel11", 4'd0, 32'd5, 32'd3, 2'b11, 2'b00, 32'd8);
        alu_test("fwd b mem", 4'd0, 32'd5, 32'd3, 2'b00, 2'b01, 32'd12);
        alu_test("sub wrap", 4'd1, 32'd3, 32'd5, 2'b00, 2'b00, 32'hFFFF_FFFE);
        alu_test("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 2'b00, 2'b00, 32'h0000_F000);
        alu_test("or", 4'd3, 32'h0000_F0F0, 32'h0000_0F00, 2'b00, 2'b00, 32'h0000_FFF0);
        alu_test("nor", 4'd4, 32'h0, 32'h0, 2'b00, 2'b00, 32'hFFFF_FFFF);
        alu_test("xor", 4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 2'b00, 2'b00, 32'hF0F0_F0F0);
        alu_test("sll low5", 4'd6, 32'd1, 32'h21, 2'b00, 2'b00, 32'd2);
        alu_test("sra", 4'd7, 32'h8000_0000, 32'd4, 2'b00, 2'b00, 32'hF800_0000);
        alu_test("srl", 4'd8, 32'h8000_0000, 32'd4, 2'b00, 2'b00, 32'h0800_0000);
        alu_test("cmd13 pass b", 4'd13, 32'd99, 32'h1234, 2'b00, 2'b00, 32'h1234);

        @(negedge clk);
        reg2_in    = 32'hAAAA;
        fwd_sel_st = 2'b10;
        #2;
        check("st_data fwd wb", st_data, 32'd1);
        fwd_sel_st = 2'b00;
        #1;
        check("st_data reg2", st_data, 32'hAAAA);

        br_test("bez taken", 32'd0, 32'd4, 32'd0, 2'b01, 1'b1, 32'h110);
        br_test("bez not", 32'd1, 32'd4, 32'd0, 2'b01, 1'b0, 32'h110);
        br_test("bne equal", 32'd5, 32'd4, 32'd5, 2'b10, 1'b0, 32'h110);
        br_test("bne taken neg", 32'd5, 32'hFFFF_FFFF, 32'd6, 2'b10, 1'b1, 32'h0FC);
        br_test("jmp", 32'd1, 32'h40, 32'd0, 2'b11, 1'b1, 32'h40);
        br_test("none", 32'd0, 32'd4, 32'd0, 2'b00, 1'b0, 32'h110);

        run_mc("mul", 4'd9, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
        run_mc("mul wrap", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_mc("div", 4'd10, 32'd100, 32'd7, 32'd14);
        run_mc("div by zero", 4'd10, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_mc("div large", 4'd10, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);

        // Flushed MUL must not start.
        @(posedge clk);
        #1;
        drive(4'd9, 32'd3, 32'd4, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        check("flushed mul stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("flushed mul busy", 32'(mc_busy), 32'd0);

        // Kill during BUSY cycle 10.
        @(posedge clk);
        #1;
        drive(4'd9, 32'd3, 32'd4, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        kill = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        check("kill busy before edge", 32'(mc_busy), 32'd1);
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill busy after", 32'(mc_busy), 32'd0);
        check("kill stall after", 32'(stall), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("kill no late done", 32'(mc_busy), 32'd0);

        // kill while idle is ignored.
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        run_mc("mul after idle kill", 4'd9, 32'd6, 32'd7, 32'd42);

        // Asynchronous reset mid-BUSY.
        @(posedge clk);
        #1;
        drive(4'd10, 32'd100, 32'd7, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst mid busy stall", 32'(stall), 32'd0);
        check("rst mid busy mc_busy", 32'(mc_busy), 32'd0);
        drive(4'd0, 32'd20, 32'd22, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_q.push_back(32'd42);
        #1;
        score("comb during reset");
        @(negedge clk);
        rst = 1'b0;

        run_mc("mul after reset", 4'd9, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
